// File: rtl/inst_fetch_if.sv
// Instruction-bus (sram-like) handshake between the fetch unit and the instruction memory.
// One request per address; addr_ok accepts it, data_ok returns the word.
interface inst_fetch_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              inst_req;
  logic [ADDR_W-1:0] inst_addr;
  logic              inst_addr_ok;
  logic              inst_data_ok;
  logic [DATA_W-1:0] inst_rdata;

  modport master (
    output inst_req,
    output inst_addr,
    input  inst_addr_ok,
    input  inst_data_ok,
    input  inst_rdata
  );

  modport slave (
    input  inst_req,
    input  inst_addr,
    output inst_addr_ok,
    output inst_data_ok,
    output inst_rdata
  );
endinterface

// File: rtl/inst_fetch.sv
// Instruction-fetch front end: one bus read per PC, buffers the word, hands {pc, inst} to ID
// and stalls the PC generator until delivery; responses in flight during a redirect are dropped.
module inst_fetch #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc,
  input  logic              flush,
  output logic              fetch_stall,
  inst_fetch_if.master      bus,
  output logic              if_valid,
  output logic [ADDR_W-1:0] if_pc,
  output logic [DATA_W-1:0] if_inst,
  output logic              if_adel,
  input  logic              id_allowin
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    VALID = 2'd3
  } state_t;

  state_t            state;
  logic              held;
  logic              cancel;
  logic              adel_r;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] buf_inst;

  logic pc_aligned;
  logic bypass;
  logic handshake;
  logic buf_load;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
    pc_aligned    = (pc[1:0] == 2'b00);
    bus.inst_req  = 1'b0;
    bus.inst_addr = '0;
    if (state == REQ) begin
      bus.inst_req  = held | pc_aligned;
      bus.inst_addr = held ? req_addr : pc;
    end

    // Returning word goes straight to ID unless it belongs to a cancelled fetch.
    bypass   = (state == WAIT) && bus.inst_data_ok && !cancel && !flush;
    if_valid = bypass || ((state == VALID) && !flush);

    if_inst = '0;
    if (bypass) begin
      if_inst = bus.inst_rdata;
    end else if ((state == VALID) && !adel_r) begin
      if_inst = buf_inst;
    end

    if_pc       = ((state == WAIT) || (state == VALID)) ? pc : '0;
    if_adel     = (state == VALID) && adel_r;
    handshake   = if_valid && id_allowin;
    fetch_stall = !handshake;
    buf_load    = bypass && !id_allowin;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state    <= IDLE;
      held     <= 1'b0;
      cancel   <= 1'b0;
      adel_r   <= 1'b0;
      req_addr <= '0;
    end else begin
      case (state)
        IDLE: state <= REQ;

        REQ: begin
          if (bus.inst_req && bus.inst_addr_ok) begin
            state  <= WAIT;
            held   <= 1'b0;
            cancel <= cancel | flush;
          end else if (flush) begin
            // An issued request may not be withdrawn: freeze its address and mark it stale.
            if (bus.inst_req) begin
              req_addr <= bus.inst_addr;
              held     <= 1'b1;
              cancel   <= 1'b1;
            end
          end else if (!held && !pc_aligned) begin
            state  <= VALID;
            adel_r <= 1'b1;
          end
        end

        WAIT: begin
          if (bus.inst_data_ok) begin
            cancel <= 1'b0;
            if (cancel || flush || id_allowin) begin
              state <= REQ;
            end else begin
              state <= VALID;
            end
          end else if (flush) begin
            cancel <= 1'b1;
          end
        end

        VALID: begin
          if (flush || handshake) begin
            state  <= REQ;
            adel_r <= 1'b0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: the instruction buffer is datapath only and is not reset; it is read solely in VALID after a load.
  always_ff @(posedge clk) begin
    if (buf_load) begin
      buf_inst <= bus.inst_rdata;
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: reset, bypass delivery, backpressure, flush in WAIT and REQ,
// misaligned PC and asynchronous reset mid-transaction.
module tb_inst_fetch;

  logic        clk;
  logic        reset;
  logic [31:0] pc;
  logic        flush;
  logic        fetch_stall;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_adel;
  logic        id_allowin;

  int n_assert;
  int n_fail;

  inst_fetch_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  inst_fetch #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .pc          (pc),
    .flush       (flush),
    .fetch_stall (fetch_stall),
    .bus         (bus),
    .if_valid    (if_valid),
    .if_pc       (if_pc),
    .if_inst     (if_inst),
    .if_adel     (if_adel),
    .id_allowin  (id_allowin)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_assert         = 0;
    n_fail           = 0;
    reset            = 1'b1;
    pc               = 32'hbfc0_0000;
    flush            = 1'b0;
    id_allowin       = 1'b1;
    bus.inst_addr_ok = 1'b0;
    bus.inst_data_ok = 1'b0;
    bus.inst_rdata   = 32'h0;
    #3;
    check("rst_stall",  fetch_stall, 1);
    check("rst_req",    bus.inst_req, 0);
    check("rst_addr",   bus.inst_addr, 0);
    check("rst_valid",  if_valid, 0);
    check("rst_adel",   if_adel, 0);
    check("rst_pc",     if_pc, 0);
    check("rst_inst",   if_inst, 0);

    // 1: reset release, addr_ok in cycle 1, data_ok bypass in cycle 2
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("t1_idle_req", bus.inst_req, 0);
    tick();
    bus.inst_addr_ok = 1'b1;
    #1;
    check("t1_req",  bus.inst_req, 1);
    check("t1_addr", bus.inst_addr, 32'hbfc0_0000);
    tick();
    bus.inst_addr_ok = 1'b0;
    bus.inst_data_ok = 1'b1;
    bus.inst_rdata   = 32'h2402_0001;
    #1;
    check("t1_valid", if_valid, 1);
    check("t1_inst",  if_inst, 32'h2402_0001);
    check("t1_pc",    if_pc, 32'hbfc0_0000);
    check("t1_stall", fetch_stall, 0);
    check("t1_noreq", bus.inst_req, 0);

    // 2: backpressure from ID for three cycles
    tick();
    pc               = 32'hbfc0_0004;
    bus.inst_data_ok = 1'b0;
    bus.inst_addr_ok = 1'b1;
    #1;
    check("t2_req",  bus.inst_req, 1);
    check("t2_addr", bus.inst_addr, 32'hbfc0_0004);
    check("t2_req_stall", fetch_stall, 1);
    tick();
    bus.inst_addr_ok = 1'b0;
    bus.inst_data_ok = 1'b1;
    bus.inst_rdata   = 32'h3c1d_0002;
    id_allowin       = 1'b0;
    #1;
    check("t2_byp_valid", if_valid, 1);
    check("t2_byp_inst",  if_inst, 32'h3c1d_0002);
    check("t2_byp_stall", fetch_stall, 1);
    for (int i = 0; i < 2; i++) begin
      tick();
      bus.inst_data_ok = 1'b0;
      bus.inst_rdata   = 32'hffff_ffff;
      #1;
      check("t2_hold_valid", if_valid, 1);
      check("t2_hold_inst",  if_inst, 32'h3c1d_0002);
      check("t2_hold_stall", fetch_stall, 1);
      check("t2_hold_noreq", bus.inst_req, 0);
      check("t2_hold_pc",    if_pc, 32'hbfc0_0004);
    end
    tick();
    id_allowin = 1'b1;
    #1;
    check("t2_hs_valid", if_valid, 1);
    check("t2_hs_inst",  if_inst, 32'h3c1d_0002);
    check("t2_hs_stall", fetch_stall, 0);

    // 3: flush in WAIT, stale word arrives two cycles later
    tick();
    pc               = 32'hbfc0_0008;
    bus.inst_addr_ok = 1'b1;
    #1;
    check("t3_req",  bus.inst_req, 1);
    check("t3_addr", bus.inst_addr, 32'hbfc0_0008);
    tick();
    bus.inst_addr_ok = 1'b0;
    flush            = 1'b1;
    #1;
    check("t3_flush_valid", if_valid, 0);
    tick();
    flush = 1'b0;
    pc    = 32'hbfc0_0380;
    #1;
    check("t3_wait_valid", if_valid, 0);
    check("t3_wait_noreq", bus.inst_req, 0);
    tick();
    bus.inst_data_ok = 1'b1;
    bus.inst_rdata   = 32'hdead_beef;
    #1;
    check("t3_drop_valid", if_valid, 0);
    check("t3_drop_stall", fetch_stall, 1);
    tick();
    bus.inst_data_ok = 1'b0;
    #1;
    check("t3_new_req",   bus.inst_req, 1);
    check("t3_new_addr",  bus.inst_addr, 32'hbfc0_0380);
    check("t3_new_valid", if_valid, 0);
    bus.inst_addr_ok = 1'b1;
    tick();
    bus.inst_addr_ok = 1'b0;
    bus.inst_data_ok = 1'b1;
    bus.inst_rdata   = 32'h8c08_0000;
    #1;
    check("t3_del_valid", if_valid, 1);
    check("t3_del_inst",  if_inst, 32'h8c08_0000);
    check("t3_del_pc",    if_pc, 32'hbfc0_0380);

    // 4: flush in REQ while addr_ok is held low
    tick();
    bus.inst_data_ok = 1'b0;
    pc               = 32'hbfc0_0384;
    flush            = 1'b1;
    #1;
    check("t4_flush_req",  bus.inst_req, 1);
    check("t4_flush_addr", bus.inst_addr, 32'hbfc0_0384);
    tick();
    flush = 1'b0;
    pc    = 32'hbfc0_0380;
    #1;
    check("t4_held_req",  bus.inst_req, 1);
    check("t4_held_addr", bus.inst_addr, 32'hbfc0_0384);
    tick();
    bus.inst_addr_ok = 1'b1;
    #1;
    check("t4_acc_addr", bus.inst_addr, 32'hbfc0_0384);
    tick();
    bus.inst_addr_ok = 1'b0;
    bus.inst_data_ok = 1'b1;
    bus.inst_rdata   = 32'hdead_beef;
    #1;
    check("t4_drop_valid", if_valid, 0);
    tick();
    bus.inst_data_ok = 1'b0;
    #1;
    check("t4_new_req",  bus.inst_req, 1);
    check("t4_new_addr", bus.inst_addr, 32'hbfc0_0380);
    bus.inst_addr_ok = 1'b1;
    tick();
    bus.inst_addr_ok = 1'b0;
    bus.inst_data_ok = 1'b1;
    bus.inst_rdata   = 32'h1111_2222;
    #1;
    check("t4_del_valid", if_valid, 1);
    check("t4_del_inst",  if_inst, 32'h1111_2222);
    check("t4_del_pc",    if_pc, 32'hbfc0_0380);

    // 5: misaligned PC raises an address error without a bus request
    tick();
    bus.inst_data_ok = 1'b0;
    pc               = 32'hbfc0_0002;
    id_allowin       = 1'b0;
    bus.inst_addr_ok = 1'b1;
    #1;
    check("t5_noreq", bus.inst_req, 0);
    check("t5_stall", fetch_stall, 1);
    tick();
    bus.inst_addr_ok = 1'b0;
    #1;
    check("t5_valid", if_valid, 1);
    check("t5_adel",  if_adel, 1);
    check("t5_inst",  if_inst, 0);
    check("t5_pc",    if_pc, 32'hbfc0_0002);
    check("t5_vnoreq", bus.inst_req, 0);
    id_allowin = 1'b1;
    #1;
    check("t5_hs_stall", fetch_stall, 0);

    // 6: asynchronous reset while waiting for data
    tick();
    pc               = 32'hbfc0_0010;
    bus.inst_addr_ok = 1'b1;
    #1;
    check("t6_adel_clr", if_adel, 0);
    check("t6_req",      bus.inst_req, 1);
    tick();
    bus.inst_addr_ok = 1'b0;
    #1;
    check("t6_wait_pc", if_pc, 32'hbfc0_0010);
    reset = 1'b1;
    #1;
    check("t6_rst_pc",    if_pc, 0);
    check("t6_rst_stall", fetch_stall, 1);
    check("t6_rst_req",   bus.inst_req, 0);
    check("t6_rst_valid", if_valid, 0);
    @(negedge clk);
    pc    = 32'hbfc0_0000;
    reset = 1'b0;
    tick();
    bus.inst_addr_ok = 1'b1;
    #1;
    check("t6_fresh_req",  bus.inst_req, 1);
    check("t6_fresh_addr", bus.inst_addr, 32'hbfc0_0000);
    tick();
    bus.inst_addr_ok = 1'b0;
    bus.inst_data_ok = 1'b1;
    bus.inst_rdata   = 32'h2402_0001;
    #1;
    check("t6_fresh_valid", if_valid, 1);
    check("t6_fresh_inst",  if_inst, 32'h2402_0001);
    tick();
    bus.inst_data_ok = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
